intersection_ctrl: RTL

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

---
 rtl/intersection_pkg.sv | 34 +++
 rtl/intersection_ctrl_phase_timer.sv | 28 ++
 rtl/intersection_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/intersection_pkg.sv
// Shared state encoding and lamp constants for the intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        WALK      = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            NS_GREEN:  return GRN;
            NS_YELLOW: return YEL;
            default:   return RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            EW_GREEN:  return GRN;
            EW_YELLOW: return YEL;
            default:   return RED;
        endcase
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase countdown: reloads on load, counts sec_tick pulses, flags the last tick.
module phase_timer #(
    parameter logic [7:0] RESET_VAL = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       expire
);

    logic [7:0] remaining;

    // The tick that consumes the final count is the one that ends the phase.
    assign expire = tick && (remaining == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= RESET_VAL;
        end else if (load) begin
            remaining <= load_val;
        end else if (tick && (remaining != 8'd0)) begin
            remaining <= remaining - 8'd1;
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way traffic light sequencer with optional pedestrian walk phase
// (enabled by defining INTERSECTION_PED_WALK_EN).
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int G_SECS = 10,
    parameter int Y_SECS = 5,
    parameter int R_SECS = 1,
    parameter int W_SECS = 10
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       sec_tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase,
    output logic       phase_start
);

    localparam logic [7:0] G_VAL = 8'(G_SECS);
    localparam logic [7:0] Y_VAL = 8'(Y_SECS);
    localparam logic [7:0] R_VAL = 8'(R_SECS);
    localparam logic [7:0] W_VAL = 8'(W_SECS);

    state_t     state;
    state_t     next_state;
    logic [7:0] next_dur;
    logic       expire;
    logic       armed;

`ifdef INTERSECTION_PED_WALK_EN
    logic ped_latch;
    logic enter_walk;
    assign enter_walk = expire && (next_state == WALK);
`endif

    always_comb begin
        next_state = state;
        case (state)
            ALL_RED_A: begin
                next_state = NS_GREEN;
`ifdef INTERSECTION_PED_WALK_EN
                if (ped_latch) next_state = WALK;
`endif
            end
            NS_GREEN:  next_state = NS_YELLOW;
            NS_YELLOW: next_state = ALL_RED_B;
            ALL_RED_B: next_state = EW_GREEN;
            EW_GREEN:  next_state = EW_YELLOW;
            EW_YELLOW: next_state = ALL_RED_A;
            WALK:      next_state = NS_GREEN;
            default:   next_state = ALL_RED_A;
        endcase
    end

    always_comb begin
        next_dur = R_VAL;
        case (next_state)
            NS_GREEN, EW_GREEN:   next_dur = G_VAL;
            NS_YELLOW, EW_YELLOW: next_dur = Y_VAL;
            WALK:                 next_dur = W_VAL;
            default:              next_dur = R_VAL;
        endcase
    end

    // Reloading on the expiring tick keeps every phase exactly its duration.
    phase_timer #(
        .RESET_VAL (R_VAL)
    ) u_timer (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .load     (expire),
        .load_val (next_dur),
        .tick     (sec_tick),
        .expire   (expire)
    );

    // armed lets the first cycle after reset release announce ALL_RED_A.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= ALL_RED_A;
            ns_light    <= RED;
            ew_light    <= RED;
            phase_start <= 1'b0;
            armed       <= 1'b0;
`ifdef INTERSECTION_PED_WALK_EN
            walk        <= 1'b0;
            ped_latch   <= 1'b0;
`endif
        end else begin
            armed       <= 1'b1;
            phase_start <= expire | ~armed;
            if (expire) begin
                state    <= next_state;
                ns_light <= ns_lamp(next_state);
                ew_light <= ew_lamp(next_state);
            end
`ifdef INTERSECTION_PED_WALK_EN
            if (expire) walk <= (next_state == WALK);
            if (enter_walk) begin
                ped_latch <= 1'b0;
            end else if (ped_req) begin
                ped_latch <= 1'b1;
            end
`endif
        end
    end

`ifndef INTERSECTION_PED_WALK_EN
    logic ped_unused;
    assign ped_unused = ped_req;
    assign walk       = 1'b0;
`endif

    assign phase = state;

endmodule
